background_fetch: RTL and testbench
===================================

# background_fetch

Pixel-rate background renderer and sole read-side client of the background tile memory. For each screen pixel requested by the VGA path it looks up the tile index in an external tile-map RAM, then fetches the 5-bit palette index from the background tile RAM. It applies a frame-synchronous horizontal scroll and returns one pixel per clock, in request order, to the colour mapper.

## Interface
Parameters:
- MAP_COLS, 64: tile-map width in 16x16 tiles; power of two.
- MAP_ROWS, 16: tile-map height in tiles; power of two.
- NUM_TILES, 24: valid tile count; the tile RAM holds NUM_TILES*256 entries, 6144 at default.

Ports (MAW = $clog2(MAP_COLS*MAP_ROWS)):
- Clk  in  1  sole clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- scroll_wr  in  1  strobe; loads scroll_x_in into the pending scroll register.
- scroll_x_in  in  11  requested horizontal scroll in pixels.
- pix_req  in  1  pixel request valid.
- DrawX, DrawY  in  10 each  screen coordinate of the request.
- map_address  out  MAW  tile-map read address, registered.
- map_data  in  5  tile index; synchronous RAM, valid one cycle after map_address.
- bg_read_address  out  19  background tile RAM read address, registered.
- bg_data  in  5  palette index; valid one cycle after bg_read_address.
- pix_valid  out  1  output pixel valid.
- pix_index  out  5  palette index.
- pix_opaque  out  1  1 = pixel comes from a valid tile.
- scroll_x_active  out  11  scroll value in force for the current frame.

## Operation
- World coordinates:
  - wx = (DrawX + scroll_x_active) mod (MAP_COLS*16), using an 11-bit sum truncated.
  - wy = DrawY mod (MAP_ROWS*16).
- Tile-map address: {wy[...:4], wx[...:4]}, row-major. Fine coordinates are fx = wx[3:0] and fy = wy[3:0].
- Tile RAM address: map_data*256 + fy*16 + fx, zero-extended to 19 bits.
- Invalid tile (map_data >= NUM_TILES):
  - bg_read_address is driven to 0.
  - An invalid flag travels down the pipe.
  - Output is pix_index = 0, pix_opaque = 0.
  - The block never drives an address >= NUM_TILES*256.
- Scroll:
  - scroll_wr writes the pending register.
  - frame_start copies pending into scroll_x_active.
  - If scroll_wr and frame_start are high in the same cycle, scroll_x_in goes directly into both registers.
  - scroll_x_active never changes outside a frame_start cycle.
- Pipeline: four stages (S1..S4) carry a valid bit, fx/fy and the invalid flag. There is no back-pressure; one request per clock is accepted unconditionally.
- Reset (Reset_n low, asynchronous) clears to 0:
  - all valid bits;
  - map_address, bg_read_address;
  - pix_valid, pix_index, pix_opaque;
  - pending scroll and scroll_x_active.
- Reset mid-stream discards every in-flight pixel. After release, the first pix_valid comes only from a new request.

## Timing
- E0, the edge sampling pix_req=1: map_address and S1 are registered.
- E1: the map RAM registers map_data.
- E2: the block samples map_data; bg_read_address and S2 are registered.
- E3: the tile RAM registers bg_data.
- E4: pix_index, pix_opaque and pix_valid are registered.
- Latency: pix_valid rises 4 clocks after the request edge.
- Throughput: 1 pixel/clock. Output order matches request order. Gaps in pix_req reproduce as gaps in pix_valid.
- pix_index and pix_opaque hold their last value while pix_valid = 0.
- A scroll update at frame_start edge F affects requests sampled at edges after F. A request sampled at edge F itself uses the old value.

## Test plan
- Reset values: assert Reset_n=0 mid-clock with random inputs -> immediately all outputs 0. After release, with pix_req held 0, pix_valid stays 0.
- Basic fetch: scroll 0, map[0]=3, tile mem[3*256+2*16+5]=7, request (5,2) -> map_address 0 after E0, bg_read_address 805 after E2, pix_valid=1 / pix_index=7 / pix_opaque=1 exactly 4 clocks after the request.
- Streaming: 640 back-to-back requests with DrawX 0..639 over a map of distinct tiles -> 640 contiguous valid outputs in order, values matching the model. A 3-cycle pix_req gap reproduces as a 3-cycle pix_valid gap.
- Scroll sync: scroll_wr with 1020 mid-frame -> scroll_x_active unchanged. After frame_start -> 1020. Request DrawX=10 -> wx=6, map column 0. Same-cycle scroll_wr=5 with frame_start -> active = 5.
- Invalid tile: map_data=24 -> bg_read_address 0, pix_index 0, pix_opaque 0. Tile 23 with fx=fy=15 -> address 6143.
- Reset with a full pipe: stream 4 requests, assert Reset_n low before any output -> no pix_valid ever appears for those requests.

Source files
------------

// File: rtl/background_fetch.sv
// Background tile renderer. Each pixel request reads the tile-map RAM and then the tile RAM.
// One palette index comes out per clock, in request order; the horizontal scroll changes only at frame_start.
module background_fetch #(
  parameter int MAP_COLS  = 64,
  parameter int MAP_ROWS  = 16,
  parameter int NUM_TILES = 24
) (
  input  logic                                   Clk,
  input  logic                                   Reset_n,
  input  logic                                   frame_start,
  input  logic                                   scroll_wr,
  input  logic [10:0]                            scroll_x_in,
  input  logic                                   pix_req,
  input  logic [9:0]                             DrawX,
  input  logic [9:0]                             DrawY,
  output logic [$clog2(MAP_COLS*MAP_ROWS)-1:0]   map_address,
  input  logic [4:0]                             map_data,
  output logic [18:0]                            bg_read_address,
  input  logic [4:0]                             bg_data,
  output logic                                   pix_valid,
  output logic [4:0]                             pix_index,
  output logic                                   pix_opaque,
  output logic [10:0]                            scroll_x_active
);
  localparam int WXW = $clog2(MAP_COLS) + 4;
  localparam int WYW = $clog2(MAP_ROWS) + 4;

  logic [10:0]    scroll_pend;
  logic [10:0]    sum_x;
  logic [WXW-1:0] wx;
  logic [WYW-1:0] wy;
  logic           tile_bad;

  logic           s1_valid, s2_valid, s3_valid, s4_valid;
  logic [3:0]     s1_fx, s1_fy, s2_fx, s2_fy;
  logic           s3_inv, s4_inv;

  // The sum is truncated to 11 bits first, and the map then wraps at its own width.
  assign sum_x    = {1'b0, DrawX} + scroll_x_active;
  assign wx       = WXW'({21'b0, sum_x} % (MAP_COLS * 16));
  assign wy       = WYW'({22'b0, DrawY} % (MAP_ROWS * 16));
  assign tile_bad = {27'b0, map_data} >= NUM_TILES;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      scroll_pend     <= '0;
      scroll_x_active <= '0;
    end else begin
      if (scroll_wr)
        scroll_pend <= scroll_x_in;
      if (frame_start)
        scroll_x_active <= scroll_wr ? scroll_x_in : scroll_pend;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid    <= 1'b0;
      s1_fx       <= '0;
      s1_fy       <= '0;
      map_address <= '0;
    end else begin
      s1_valid <= pix_req;
      if (pix_req) begin
        map_address <= {wy[WYW-1:4], wx[WXW-1:4]};
        s1_fx       <= wx[3:0];
        s1_fy       <= wy[3:0];
      end
    end
  end

  // S2 only waits for the map RAM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid <= 1'b0;
      s2_fx    <= '0;
      s2_fy    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_fx    <= s1_fx;
      s2_fy    <= s1_fy;
    end
  end

  // An out-of-range tile reads address 0 so the tile RAM is never addressed past its end.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s3_valid        <= 1'b0;
      s3_inv          <= 1'b0;
      bg_read_address <= '0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_inv          <= tile_bad;
        bg_read_address <= tile_bad ? '0 : 19'({map_data, s2_fy, s2_fx});
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s4_valid <= 1'b0;
      s4_inv   <= 1'b0;
    end else begin
      s4_valid <= s3_valid;
      s4_inv   <= s3_inv;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_valid  <= 1'b0;
      pix_index  <= '0;
      pix_opaque <= 1'b0;
    end else begin
      pix_valid <= s4_valid;
      if (s4_valid) begin
        pix_index  <= s4_inv ? '0 : bg_data;
        pix_opaque <= ~s4_inv;
      end
    end
  end

endmodule

// File: tb/tb_background_fetch.sv
// Bench for background_fetch: behavioural tile/scroll model with per-cycle compare, plus directed literal checks.
module tb_background_fetch;
  logic        Clk;
  logic        Reset_n;
  logic        frame_start, scroll_wr, pix_req;
  logic [10:0] scroll_x_in;
  logic [9:0]  DrawX, DrawY;
  logic [9:0]  map_address;
  logic [4:0]  map_data;
  logic [18:0] bg_read_address;
  logic [4:0]  bg_data;
  logic        pix_valid, pix_opaque;
  logic [4:0]  pix_index;
  logic [10:0] scroll_x_active;

  logic [4:0] map_mem [1024];
  logic [4:0] tile_mem [8192];

  typedef struct { int due; int idx; int op; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int m_pend = 0, m_act = 0;
  int last_idx = 0, last_op = 0;
  int valid_cnt = 0;

  background_fetch #(.MAP_COLS(64), .MAP_ROWS(16), .NUM_TILES(24)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .scroll_wr(scroll_wr),
    .scroll_x_in(scroll_x_in), .pix_req(pix_req), .DrawX(DrawX), .DrawY(DrawY),
    .map_address(map_address), .map_data(map_data), .bg_read_address(bg_read_address),
    .bg_data(bg_data), .pix_valid(pix_valid), .pix_index(pix_index),
    .pix_opaque(pix_opaque), .scroll_x_active(scroll_x_active)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  // Synchronous RAMs with one cycle of read latency.
  always @(posedge Clk) begin
    map_data <= map_mem[map_address];
    bg_data  <= tile_mem[bg_read_address];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_pix(input int dx, input int dy, input int sx,
                                    output int idx, output int op);
    int wx, wy, tile, addr;
    wx   = ((dx + sx) % 2048) % 1024;
    wy   = dy % 256;
    tile = int'(map_mem[(wy / 16) * 64 + wx / 16]);
    addr = tile * 256 + (wy % 16) * 16 + (wx % 16);
    if (tile >= 24) begin
      idx = 0;
      op  = 0;
    end else begin
      idx = int'(tile_mem[addr]);
      op  = 1;
    end
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      exp_q.delete();
      m_pend   = 0;
      m_act    = 0;
      last_idx = 0;
      last_op  = 0;
    end else begin
      exp_t e;
      int ti, to;
      cyc++;
      if (pix_req) begin
        model_pix(int'(DrawX), int'(DrawY), m_act, ti, to);
        e.due = cyc + 4;
        e.idx = ti;
        e.op  = to;
        exp_q.push_back(e);
      end
      if (frame_start) m_act = scroll_wr ? int'(scroll_x_in) : m_pend;
      if (scroll_wr) m_pend = int'(scroll_x_in);
    end
  end

  always @(negedge Clk) begin
    if (Reset_n) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("pix_valid", int'(pix_valid), 1);
        chk("pix_index", int'(pix_index), exp_q[0].idx);
        chk("pix_opaque", int'(pix_opaque), exp_q[0].op);
        last_idx = exp_q[0].idx;
        last_op  = exp_q[0].op;
        void'(exp_q.pop_front());
      end else begin
        chk("pix_valid_idle", int'(pix_valid), 0);
        chk("pix_index_hold", int'(pix_index), last_idx);
        chk("pix_opaque_hold", int'(pix_opaque), last_op);
      end
      if (pix_valid) valid_cnt++;
      chk("scroll_x_active", int'(scroll_x_active), m_act);
      chk("bg_addr_range", int'(bg_read_address < 19'd6144), 1);
    end
  end

  task automatic rand_inputs();
    pix_req     = 1'($urandom_range(0, 1));
    DrawX       = 10'($urandom);
    DrawY       = 10'($urandom);
    scroll_wr   = ($urandom_range(0, 3) == 0);
    frame_start = ($urandom_range(0, 3) == 0);
    scroll_x_in = 11'($urandom);
  endtask

  task automatic zero_inputs();
    pix_req = 0; DrawX = 0; DrawY = 0;
    scroll_wr = 0; frame_start = 0; scroll_x_in = 0;
  endtask

  initial begin
    zero_inputs();
    Reset_n = 1;
    for (int a = 0; a < 8192; a++) tile_mem[a] = 5'(a * 7 + (a >> 8));
    for (int i = 0; i < 1024; i++) map_mem[i] = 5'(i + i / 64);
    #1 Reset_n = 0;
    repeat (2) @(negedge Clk);
    Reset_n = 1;

    // Random traffic, then asynchronous reset in mid-clock.
    repeat (20) begin
      @(negedge Clk);
      rand_inputs();
    end
    @(posedge Clk);
    #3 Reset_n = 0;
    #1;
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_pix_index", int'(pix_index), 0);
    chk("rst_pix_opaque", int'(pix_opaque), 0);
    chk("rst_map_address", int'(map_address), 0);
    chk("rst_bg_address", int'(bg_read_address), 0);
    chk("rst_scroll_active", int'(scroll_x_active), 0);
    repeat (2) begin
      @(negedge Clk);
      rand_inputs();
    end
    @(negedge Clk);
    zero_inputs();
    Reset_n = 1;
    valid_cnt = 0;
    repeat (8) @(negedge Clk);
    chk("idle_after_reset", valid_cnt, 0);

    // Basic fetch.
    map_mem[0] = 5'd3;
    tile_mem[805] = 5'd7;
    pix_req = 1; DrawX = 5; DrawY = 2;
    @(negedge Clk);
    pix_req = 0;
    chk("basic_map_addr", int'(map_address), 0);
    repeat (2) @(negedge Clk);
    chk("basic_bg_addr", int'(bg_read_address), 805);
    repeat (2) @(negedge Clk);
    chk("basic_valid", int'(pix_valid), 1);
    chk("basic_index", int'(pix_index), 7);
    chk("basic_opaque", int'(pix_opaque), 1);
    repeat (4) @(negedge Clk);

    // Streaming a full line, a 3-cycle gap, then a short burst.
    valid_cnt = 0;
    for (int x = 0; x < 640; x++) begin
      pix_req = 1; DrawX = 10'(x); DrawY = 10'd37;
      @(negedge Clk);
    end
    pix_req = 0;
    repeat (3) @(negedge Clk);
    for (int x = 0; x < 5; x++) begin
      pix_req = 1; DrawX = 10'(100 + x * 16); DrawY = 10'd200;
      @(negedge Clk);
    end
    pix_req = 0;
    repeat (8) @(negedge Clk);
    chk("stream_count", valid_cnt, 645);

    // Scroll synchronisation.
    scroll_wr = 1; scroll_x_in = 11'd1020;
    @(negedge Clk);
    scroll_wr = 0;
    chk("scroll_pending_only", int'(scroll_x_active), 0);
    frame_start = 1; pix_req = 1; DrawX = 10'd100; DrawY = 10'd0;
    @(negedge Clk);
    frame_start = 0; pix_req = 0;
    chk("scroll_old_at_F", int'(map_address), 6);
    chk("scroll_applied", int'(scroll_x_active), 1020);
    pix_req = 1; DrawX = 10'd10; DrawY = 10'd16;
    @(negedge Clk);
    pix_req = 0;
    chk("scroll_wrap_addr", int'(map_address), 64);
    scroll_wr = 1; scroll_x_in = 11'd5; frame_start = 1;
    @(negedge Clk);
    scroll_wr = 0; frame_start = 0;
    chk("scroll_same_cycle", int'(scroll_x_active), 5);
    repeat (6) @(negedge Clk);

    // Last valid tile at its far corner, then an invalid tile (scroll is 5).
    map_mem[2] = 5'd23;
    map_mem[1] = 5'd24;
    tile_mem[6143] = 5'd9;
    pix_req = 1; DrawX = 10'd42; DrawY = 10'd15;
    @(negedge Clk);
    DrawX = 10'd11; DrawY = 10'd0;
    @(negedge Clk);
    pix_req = 0;
    @(negedge Clk);
    chk("tile23_addr", int'(bg_read_address), 6143);
    @(negedge Clk);
    chk("invalid_addr", int'(bg_read_address), 0);
    @(negedge Clk);
    chk("tile23_index", int'(pix_index), 9);
    chk("tile23_opaque", int'(pix_opaque), 1);
    @(negedge Clk);
    chk("invalid_valid", int'(pix_valid), 1);
    chk("invalid_index", int'(pix_index), 0);
    chk("invalid_opaque", int'(pix_opaque), 0);
    repeat (4) @(negedge Clk);

    // Reset with the pipe full: none of these four may ever emerge.
    valid_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      pix_req = 1; DrawX = 10'(k * 16); DrawY = 10'd3;
      @(negedge Clk);
    end
    pix_req = 0;
    #2 Reset_n = 0;
    repeat (2) @(negedge Clk);
    Reset_n = 1;
    repeat (10) @(negedge Clk);
    chk("flush_no_valid", valid_cnt, 0);
    chk("flush_scroll", int'(scroll_x_active), 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
